// File: rtl/mux_pkg.sv
// Shared encodings for the registered N-channel scan multiplexer.
// The FSM state values and the mode input encoding live here.
package mux_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAN  = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    localparam logic MODE_MAN  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MAN  = ST_MAN,
        SCAN = ST_SCAN
    } mux_state_t;

endpackage

// File: rtl/mux_sel_ctr.sv
// Channel-select register: manual load, round-robin advance, wrap pulse,
// sticky out-of-range load flag and the one-hot select probe.
module mux_sel_ctr
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             adv,
    output logic [SEL_W-1:0] cur_sel,
    output logic [N_CH-1:0]  sel_onehot,
    output logic             wrap,
    output logic             sel_err
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic sel_in_ok;
    logic at_last;

    assign sel_in_ok = (32'(sel_in) < 32'(N_CH));
    assign at_last   = (cur_sel == LAST_CH);

    // A load always takes priority over a scan step, even an out-of-range one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sel <= '0;
            wrap    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                if (sel_in_ok) begin
                    cur_sel <= sel_in;
                end else begin
                    sel_err <= 1'b1;
                end
            end else if (adv) begin
                if (at_last) begin
                    cur_sel <= '0;
                    wrap    <= 1'b1;
                end else begin
                    cur_sel <= cur_sel + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        for (int k = 0; k < N_CH; k++) begin
            sel_onehot[k] = (cur_sel == SEL_W'(k));
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel W-bit mux with valid/ready output stage,
// manual select and round-robin auto-scan.
//
// state | meaning
// IDLE  | en low, no captures
// MAN   | capture from the manually loaded channel
// SCAN  | capture and step round-robin through channels
module mux_scan_n
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 8,
    localparam int SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [N_CH*W-1:0] din,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [W-1:0]      dout,
    output logic [SEL_W-1:0]  dout_ch,
    output logic [SEL_W-1:0]  cur_sel,
    output logic [N_CH-1:0]   sel_onehot,
    output logic              wrap,
    output logic              sel_err
);

    mux_state_t state_q;
    mux_state_t state_d;

    logic         cap;
    logic         adv;
    logic [W-1:0] mux_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (en) begin
            case (mode)
                MODE_MAN:  state_d = MAN;
                MODE_SCAN: state_d = SCAN;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Capture needs the registered state, so the first edge after en rises only
    // switches state; sampling starts one edge later.
    assign cap = ((state_q == MAN) || (state_q == SCAN)) && en && (!out_valid || out_ready);
    assign adv = cap && (state_q == SCAN);

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                mux_data = din[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            dout_ch   <= '0;
        end else if (cap) begin
            out_valid <= 1'b1;
            dout      <= mux_data;
            dout_ch   <= cur_sel;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    mux_sel_ctr #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_sel_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .sel_in     (sel_in),
        .adv        (adv),
        .cur_sel    (cur_sel),
        .sel_onehot (sel_onehot),
        .wrap       (wrap),
        .sel_err    (sel_err)
    );

endmodule
